// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and index helpers for the NTT zeta table writer.
// Supplies the DATA_WIDTH / NTT_STAGE_CNT build defaults when the integration does not.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 7
`endif

package ntt_pkg;

  localparam int NTT_Q           = 3329;
  localparam int NTT_ZETA        = 17;
  localparam int NTT_MONT_R_MODQ = 2285;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECOMP,
    ST_ENTRY,
    ST_WRITE,
    ST_DONE
  } zt_state_e;

  function automatic logic [15:0] brv(input logic [15:0] k, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) r[i] = k[n-1-i];
    end
    return r;
  endfunction

  // Returns {stage, addr}: stage = floor(log2 k), addr = k with its leading one cleared.
  function automatic logic [31:0] decode_k(input logic [15:0] k);
    logic [15:0] s;
    logic [15:0] a;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) s = 16'(i);
    end
    a = k & ~(16'd1 << s);
    return {s, a};
  endfunction

endpackage

// File: rtl/zeta_table_writer_if.sv
// Controller/RAM-side bundle of the zeta table writer: start/busy/done plus the RAM write port.
interface zeta_table_writer_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int STAGE_CNT  = `NTT_STAGE_CNT
);
  localparam int SW = $clog2(STAGE_CNT);
  localparam int AW = STAGE_CNT - 1;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [SW-1:0]         wr_stage;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    input  start,
    output busy, done, wr_en, wr_stage, wr_addr, wr_data
  );

  modport slave (
    output start,
    input  busy, done, wr_en, wr_stage, wr_addr, wr_data
  );
endinterface

// File: rtl/zeta_modmul.sv
// a*b mod Q with Barrett reduction; fixed 2-cycle latency, no stall.
// Stage 1 registers the full product, stage 2 registers the fully reduced remainder.
module zeta_modmul #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int Q          = 3329
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_res
);
  localparam int K = 2 * DATA_WIDTH;
  localparam logic [K-1:0] BARRETT_M = K'((64'd1 << K) / Q);
  localparam logic [K-1:0] QK        = K'(Q);

  logic [K-1:0]          r_prod;
  logic [DATA_WIDTH-1:0] r_res;
  logic [2*K-1:0]        w_qm;
  logic [K-1:0]          w_q;
  logic [K-1:0]          w_qq;
  logic [K-1:0]          w_rem;

  // Quotient estimate is at most one short, so the remainder lands in [0, 2Q).
  always_comb begin
    w_qm  = {{K{1'b0}}, r_prod} * {{K{1'b0}}, BARRETT_M};
    w_q   = K'(w_qm >> K);
    w_qq  = w_q * QK;
    w_rem = r_prod - w_qq;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prod <= '0;
      r_res  <= '0;
    end else begin
      r_prod <= {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};
      r_res  <= (w_rem >= QK) ? DATA_WIDTH'(w_rem - QK) : DATA_WIDTH'(w_rem);
    end
  end

  assign o_res = r_res;
endmodule

// File: rtl/zeta_table_writer.sv
// Run-time NTT zeta table generator: streams zeta^brv(k) mod Q, stage-major, k ascending.
// Build option ZETA_MONT_EN: values are written scaled by 2^16 mod Q (Montgomery domain).
//   state   | meaning
//   IDLE    | waiting for start
//   PRECOMP | p[b] = p[b-1]^2, b = 1..STAGE_CNT-1
//   ENTRY   | acc *= e[b] ? p[b] : 1, one 3-cycle step per exponent bit
//   WRITE   | write strobe for entry k, then k++
//   DONE    | one-cycle done pulse
module zeta_table_writer
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int STAGE_CNT   = `NTT_STAGE_CNT,
  parameter int Q           = NTT_Q,
  parameter int ZETA        = NTT_ZETA,
  parameter int MONT_R_MODQ = NTT_MONT_R_MODQ
) (
  input  logic                i_clk,
  input  logic                i_rst,
  zeta_table_writer_if.master bus
);
  localparam int SW = $clog2(STAGE_CNT);
  localparam int AW = STAGE_CNT - 1;
  localparam int KW = STAGE_CNT;
`ifdef ZETA_MONT_EN
  localparam bit MONT_EN = 1'b1;
`else
  localparam bit MONT_EN = 1'b0;
`endif
  localparam logic [DATA_WIDTH-1:0] ACC_INIT =
    MONT_EN ? DATA_WIDTH'(MONT_R_MODQ) : DATA_WIDTH'(1);
  localparam logic [KW-1:0] K_LAST     = '1;
  localparam logic [SW-1:0] BIT_LAST   = SW'(STAGE_CNT - 1);
  localparam logic [1:0]    PH_ISSUE   = 2'd2;
  localparam logic [1:0]    PH_CAPTURE = 2'd0;

  zt_state_e             r_state;
  zt_state_e             w_nxt_state;
  logic [KW-1:0]         r_k;
  logic [SW-1:0]         r_bit;
  logic [1:0]            r_phase;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_pow [STAGE_CNT];

  logic                  r_busy;
  logic                  r_done;
  logic                  r_wr_en;
  logic [SW-1:0]         r_wr_stage;
  logic [AW-1:0]         r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic [KW-1:0]         w_exp;
  logic [SW-1:0]         w_prev_bit;
  logic                  w_cap;
  logic                  w_bit_last;
  logic [DATA_WIDTH-1:0] w_mul_a;
  logic [DATA_WIDTH-1:0] w_mul_b;
  logic [DATA_WIDTH-1:0] w_mul_res;

  assign w_exp      = KW'(brv(16'(r_k), STAGE_CNT));
  assign w_prev_bit = r_bit - SW'(1);
  assign w_cap      = (r_phase == PH_CAPTURE);
  assign w_bit_last = (r_bit == BIT_LAST);

  zeta_modmul #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q          (Q)
  ) u_modmul (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_a   (w_mul_a),
    .i_b   (w_mul_b),
    .o_res (w_mul_res)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_nxt_state;
  end

  // Operands are held for the whole step; the multiplier only samples them in the issue cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_mul_a     = r_acc;
    w_mul_b     = DATA_WIDTH'(1);
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_nxt_state = ST_PRECOMP;
      end
      ST_PRECOMP: begin
        w_mul_a = r_pow[w_prev_bit];
        w_mul_b = r_pow[w_prev_bit];
        if (w_cap && w_bit_last) w_nxt_state = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (w_exp[r_bit]) w_mul_b = r_pow[r_bit];
        if (w_cap && w_bit_last) w_nxt_state = ST_WRITE;
      end
      ST_WRITE: begin
        w_nxt_state = (r_k == K_LAST) ? ST_DONE : ST_ENTRY;
      end
      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_k        <= '0;
      r_bit      <= '0;
      r_phase    <= '0;
      r_acc      <= '0;
      for (int i = 0; i < STAGE_CNT; i++) r_pow[i] <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_stage <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_busy  <= (w_nxt_state == ST_PRECOMP) || (w_nxt_state == ST_ENTRY) ||
                 (w_nxt_state == ST_WRITE);
      r_done  <= (w_nxt_state == ST_DONE);
      r_wr_en <= (w_nxt_state == ST_WRITE);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_pow[0] <= DATA_WIDTH'(ZETA);
            r_k      <= KW'(1);
            r_bit    <= SW'(1);
            r_phase  <= PH_ISSUE;
          end
        end
        ST_PRECOMP: begin
          if (w_cap) begin
            r_pow[r_bit] <= w_mul_res;
            r_phase      <= PH_ISSUE;
            if (w_bit_last) begin
              r_bit <= '0;
              r_acc <= ACC_INIT;
            end else begin
              r_bit <= r_bit + SW'(1);
            end
          end else begin
            r_phase <= r_phase - 2'd1;
          end
        end
        ST_ENTRY: begin
          if (w_cap) begin
            r_acc   <= w_mul_res;
            r_phase <= PH_ISSUE;
            if (w_bit_last) begin
              r_bit      <= '0;
              r_wr_stage <= SW'(decode_k(16'(r_k)) >> 16);
              r_wr_addr  <= AW'(decode_k(16'(r_k)));
              r_wr_data  <= w_mul_res;
            end else begin
              r_bit <= r_bit + SW'(1);
            end
          end else begin
            r_phase <= r_phase - 2'd1;
          end
        end
        ST_WRITE: begin
          r_k     <= r_k + KW'(1);
          r_bit   <= '0;
          r_phase <= PH_ISSUE;
          r_acc   <= ACC_INIT;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_stage = r_wr_stage;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
endmodule

// File: tb/tb_zeta_table_writer.sv
// Directed bench for zeta_table_writer: hand vectors, golden power model, start/reset corner cases.
module tb_zeta_table_writer;
  localparam int NK     = 128;
  localparam int QM     = 3329;
  localparam int RUN_CY = 2830;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  zeta_table_writer_if bus ();

  zeta_table_writer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    int k;
    int stage;
    int addr;
    int data;   // -1: take from the power model
    int cyc;
  } vec_t;

  vec_t vecs [6];
  int   n_vec;
  int   n_err;
  int   n_wr;
  int   got_cyc   [NK];
  int   got_stage [NK];
  int   got_addr  [NK];
  int   got_data  [NK];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int brv7(input int k);
    int e;
    e = 0;
    for (int i = 0; i < 7; i++) if (((k >> i) & 1) != 0) e = e | (1 << (6 - i));
    return e;
  endfunction

  function automatic int model(input int k);
    int r;
    int e;
    r = 1;
    e = brv7(k);
    for (int i = 0; i < e; i++) r = (r * 17) % QM;
`ifdef ZETA_MONT_EN
    r = (r * 2285) % QM;
`endif
    return r;
  endfunction

  function automatic int stage_of(input int k);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) if (((k >> i) & 1) != 0) s = i;
    return s;
  endfunction

  // Cycle c is observed at the falling edge inside it; cycle 0 is the one whose end samples start.
  task automatic run_seq(input bit started, input bit poke, input bit chain);
    bit exp_wr;
    n_wr = 0;
    for (int i = 0; i < NK; i++) begin
      got_cyc[i] = -1; got_stage[i] = -1; got_addr[i] = -1; got_data[i] = -1;
    end
    if (!started) begin
      @(negedge clk);
      bus.start = 1'b1;
    end
    for (int c = 1; c <= RUN_CY; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      exp_wr = (c >= 40) && (c <= 2812) && (((c - 18) % 22) == 0);
      chk("busy", 32'(bus.busy), 32'(c <= 2812));
      chk("done", 32'(bus.done), 32'(c == 2813));
      chk("wr_en", 32'(bus.wr_en), 32'(exp_wr));
      if (bus.wr_en === 1'b1 && n_wr < NK - 1) begin
        n_wr++;
        got_cyc[n_wr]   = c;
        got_stage[n_wr] = int'(bus.wr_stage);
        got_addr[n_wr]  = int'(bus.wr_addr);
        got_data[n_wr]  = int'(bus.wr_data);
      end
      if (poke && (c == 5 || c == 2813)) bus.start = 1'b1;
      if (chain && c == 2814) begin
        bus.start = 1'b1;
        break;
      end
    end
    chk("write_count", 32'(n_wr), 32'd127);
    chk("last_write_cycle", 32'(got_cyc[127]), 32'd2812);
    for (int v = 0; v < 6; v++) begin
      chk("vec_stage", 32'(got_stage[vecs[v].k]), 32'(vecs[v].stage));
      chk("vec_addr", 32'(got_addr[vecs[v].k]), 32'(vecs[v].addr));
      chk("vec_data", 32'(got_data[vecs[v].k]),
          32'((vecs[v].data < 0) ? model(vecs[v].k) : vecs[v].data));
      chk("vec_cycle", 32'(got_cyc[vecs[v].k]), 32'(vecs[v].cyc));
    end
    for (int k = 1; k < NK; k++) begin
      chk("model_data", 32'(got_data[k]), 32'(model(k)));
      chk("model_stage", 32'(got_stage[k]), 32'(stage_of(k)));
      chk("model_addr", 32'(got_addr[k]), 32'(k - (1 << stage_of(k))));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},     32'(bus.busy),     32'd0);
    chk({tag, "_done"},     32'(bus.done),     32'd0);
    chk({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    chk({tag, "_wr_stage"}, 32'(bus.wr_stage), 32'd0);
    chk({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
    chk({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef ZETA_MONT_EN
    vecs[0] = '{k: 1,   stage: 0, addr: 0,  data: 2571, cyc: 40};
    vecs[1] = '{k: 2,   stage: 1, addr: 0,  data: 2970, cyc: 62};
    vecs[2] = '{k: 3,   stage: 1, addr: 1,  data: 1812, cyc: 84};
    vecs[3] = '{k: 4,   stage: 2, addr: 0,  data: 1493, cyc: 106};
    vecs[4] = '{k: 64,  stage: 6, addr: 0,  data: 2226, cyc: 1426};
`else
    vecs[0] = '{k: 1,   stage: 0, addr: 0,  data: 1729, cyc: 40};
    vecs[1] = '{k: 2,   stage: 1, addr: 0,  data: 2580, cyc: 62};
    vecs[2] = '{k: 3,   stage: 1, addr: 1,  data: 3289, cyc: 84};
    vecs[3] = '{k: 4,   stage: 2, addr: 0,  data: 2642, cyc: 106};
    vecs[4] = '{k: 64,  stage: 6, addr: 0,  data: 17,   cyc: 1426};
`endif
    vecs[5] = '{k: 127, stage: 6, addr: 63, data: -1,   cyc: 2812};

    rst       = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("idle");

    // Run with start pulses while busy and in DONE, chained into a back-to-back run.
    run_seq(1'b0, 1'b1, 1'b1);
    run_seq(1'b1, 1'b0, 1'b0);

    // Reset in the middle of a run, then a fresh complete run.
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midrst");
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("post_rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
    end
    run_seq(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
